// File: rtl/chan_pkg.sv
// Shared types and constants for the channel error injector.
package chan_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_RANDOM   = 2'd2,
        MODE_BURST    = 2'd3
    } chan_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } chan_state_e;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

endpackage

// File: rtl/lfsr_gen.sv
// Right-shift Galois LFSR; advances one step per cycle with adv_i high.
module lfsr_gen #(
    parameter int           W    = 16,
    parameter logic [W-1:0] SEED = W'(16'hACE1),
    parameter logic [W-1:0] TAPS = W'(16'hB400)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (adv_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/chan_err_inj.sv
// Channel model: XORs a mask onto selected encoder symbols (off/periodic/random/burst).
// Injection statistics counters are built only with CHAN_ERR_INJ_STATS_EN defined.
//
// state    | meaning
// ST_IDLE  | waiting for a periodic trigger
// ST_BURST | corrupting the remaining symbols of a burst
// ST_DONE  | injection window exhausted, no injection until rst
module chan_err_inj
    import chan_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF),
    parameter int                CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [1:0]       sym_i,
    input  logic [1:0]       mode_i,
    input  logic [7:0]       period_i,
    input  logic [3:0]       rate_i,
    input  logic [3:0]       burst_len_i,
    input  logic [1:0]       mask_i,
    input  logic [CNT_W-1:0] window_i,
    output logic             valid_o,
    output logic [1:0]       sym_o,
    output logic [1:0]       err_o,
    output logic [CNT_W-1:0] sym_ct_o,
    output logic [CNT_W-1:0] err_sym_ct_o,
    output logic [CNT_W-1:0] err_bit_ct_o
);

    chan_mode_e         mode;
    chan_state_e        state_q;
    logic [7:0]         phase_q;
    logic [3:0]         burst_q;
    logic [CNT_W-1:0]   sym_ct_q;
    logic               valid_o_q;
    logic [1:0]         sym_o_q;
    logic [1:0]         err_o_q;

    logic [LFSR_W-1:0]  lfsr;
    logic [LFSR_W-1:0]  rate_mask;
    logic               trig;
    logic               rnd;
    logic               eligible;
    logic               win_hit;
    logic [3:0]         len_eff;
    logic [1:0]         inj_mask;
    logic [CNT_W:0]     sym_ct_inc;

    lfsr_gen #(
        .W    (LFSR_W),
        .SEED (LFSR_SEED),
        .TAPS (LFSR_W'(LFSR_TAPS))
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (valid_i),
        .state_o (lfsr)
    );

    assign mode       = chan_mode_e'(mode_i);
    assign rate_mask  = (LFSR_W'(1) << rate_i) - LFSR_W'(1);
    assign rnd        = (lfsr & rate_mask) == '0;
    assign trig       = (period_i != 8'd0) && (phase_q == period_i - 8'd1);
    assign eligible   = (window_i == '0) || (sym_ct_q < window_i);
    assign sym_ct_inc = {1'b0, sym_ct_q} + (CNT_W+1)'(1);
    // Window closes once the count reaches window_i, even if window_i was lowered mid-run.
    assign win_hit    = (window_i != '0) && (sym_ct_inc >= {1'b0, window_i});
    assign len_eff    = (burst_len_i == 4'd0) ? 4'd1 : burst_len_i;

    always_comb begin
        inj_mask = 2'b00;
        if (valid_i && eligible && (state_q != ST_DONE)) begin
            case (mode)
                MODE_PERIODIC: if (trig) inj_mask = mask_i;
                MODE_RANDOM:   if (rnd)  inj_mask = mask_i;
                MODE_BURST: begin
                    if ((state_q == ST_BURST) || ((state_q == ST_IDLE) && trig)) begin
                        inj_mask = mask_i;
                    end
                end
                default: inj_mask = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= 8'd0;
            burst_q   <= 4'd0;
            sym_ct_q  <= '0;
            valid_o_q <= 1'b0;
            sym_o_q   <= 2'b00;
            err_o_q   <= 2'b00;
        end else begin
            valid_o_q <= valid_i;
            sym_o_q   <= sym_i ^ inj_mask;
            err_o_q   <= inj_mask;

            if (valid_i) begin
                phase_q <= trig ? 8'd0 : phase_q + 8'd1;
                if (!sym_ct_inc[CNT_W]) begin
                    sym_ct_q <= sym_ct_inc[CNT_W-1:0];
                end
            end

            if (valid_i && win_hit) begin
                state_q <= ST_DONE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (valid_i && (mode == MODE_BURST) && trig && eligible && (len_eff > 4'd1)) begin
                            state_q <= ST_BURST;
                            burst_q <= len_eff - 4'd1;
                        end
                    end
                    ST_BURST: begin
                        if (mode != MODE_BURST) begin
                            state_q <= ST_IDLE;
                        end else if (valid_i) begin
                            burst_q <= burst_q - 4'd1;
                            if (burst_q <= 4'd1) begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    default: state_q <= ST_DONE;
                endcase
            end
        end
    end

`ifdef CHAN_ERR_INJ_STATS_EN
    logic [CNT_W-1:0] err_sym_q;
    logic [CNT_W-1:0] err_bit_q;
    logic [CNT_W:0]   err_sym_inc;
    logic [CNT_W:0]   err_bit_inc;
    logic [1:0]       pop;

    assign pop         = {1'b0, inj_mask[1]} + {1'b0, inj_mask[0]};
    assign err_sym_inc = {1'b0, err_sym_q} + (CNT_W+1)'(1);
    assign err_bit_inc = {1'b0, err_bit_q} + (CNT_W+1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sym_q <= '0;
            err_bit_q <= '0;
        end else if (inj_mask != 2'b00) begin
            err_sym_q <= err_sym_inc[CNT_W] ? '1 : err_sym_inc[CNT_W-1:0];
            err_bit_q <= err_bit_inc[CNT_W] ? '1 : err_bit_inc[CNT_W-1:0];
        end
    end

    assign err_sym_ct_o = err_sym_q;
    assign err_bit_ct_o = err_bit_q;
`else
    assign err_sym_ct_o = '0;
    assign err_bit_ct_o = '0;
`endif

    assign valid_o  = valid_o_q;
    assign sym_o    = sym_o_q;
    assign err_o    = err_o_q;
    assign sym_ct_o = sym_ct_q;

endmodule

// File: tb/tb_chan_err_inj.sv
// Directed bench for chan_err_inj: mode patterns, window, gaps and mid-burst reset.
module tb_chan_err_inj;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [1:0]  sym_i;
    logic [1:0]  mode_i;
    logic [7:0]  period_i;
    logic [3:0]  rate_i;
    logic [3:0]  burst_len_i;
    logic [1:0]  mask_i;
    logic [31:0] window_i;
    logic        valid_o;
    logic [1:0]  sym_o;
    logic [1:0]  err_o;
    logic [31:0] sym_ct_o;
    logic [31:0] err_sym_ct_o;
    logic [31:0] err_bit_ct_o;

    int n_chk = 0;
    int n_bad = 0;

`ifdef CHAN_ERR_INJ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    chan_err_inj dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .sym_i        (sym_i),
        .mode_i       (mode_i),
        .period_i     (period_i),
        .rate_i       (rate_i),
        .burst_len_i  (burst_len_i),
        .mask_i       (mask_i),
        .window_i     (window_i),
        .valid_o      (valid_o),
        .sym_o        (sym_o),
        .err_o        (err_o),
        .sym_ct_o     (sym_ct_o),
        .err_sym_ct_o (err_sym_ct_o),
        .err_bit_ct_o (err_bit_ct_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic send(input logic v, input logic [1:0] s);
        valid_i = v;
        sym_i   = s;
        @(negedge clk);
    endtask

    task automatic send_chk(input string tag, input logic [1:0] s, input logic [1:0] e);
        send(1'b1, s);
        chk({tag, "_v"}, 32'(valid_o), 32'd1);
        chk({tag, "_err"}, 32'(err_o), 32'(e));
        chk({tag, "_sym"}, 32'(sym_o), 32'(s ^ e));
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] m, input logic [7:0] p, input logic [3:0] r,
                       input logic [3:0] bl, input logic [1:0] mk, input logic [31:0] w);
        mode_i = m; period_i = p; rate_i = r; burst_len_i = bl; mask_i = mk; window_i = w;
    endtask

    initial begin
        logic [15:0] l;
        logic [1:0]  e;
        int          cnt;

        rst = 1'b1; valid_i = 1'b1; sym_i = 2'b11;
        cfg(2'd1, 8'd1, 4'd0, 4'd1, 2'b11, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_sym", 32'(sym_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_symct", sym_ct_o, 32'd0);
        chk("rst_errsym", err_sym_ct_o, 32'd0);
        chk("rst_errbit", err_bit_ct_o, 32'd0);

        // OFF
        cfg(2'd0, 8'd8, 4'd0, 4'd3, 2'b11, 32'd0);
        reset_dut();
        for (int k = 0; k < 300; k++) send_chk("off", 2'b10, 2'b00);
        chk("off_symct", sym_ct_o, 32'd300);
        chk("off_errsym", err_sym_ct_o, 32'd0);
        chk("off_errbit", err_bit_ct_o, 32'd0);

        // PERIODIC with window
        cfg(2'd1, 8'd8, 4'd0, 4'd1, 2'b01, 32'd256);
        reset_dut();
        for (int k = 0; k < 300; k++)
            send_chk("per", 2'b00, ((k % 8 == 7) && (k < 256)) ? 2'b01 : 2'b00);
        chk("per_symct", sym_ct_o, 32'd300);
        chk("per_errsym", err_sym_ct_o, stat(32));
        chk("per_errbit", err_bit_ct_o, stat(32));

        // BURST
        cfg(2'd3, 8'd16, 4'd0, 4'd3, 2'b11, 32'd0);
        reset_dut();
        for (int k = 0; k < 64; k++)
            send_chk("bst", 2'b00, ((k % 16) >= 15 || ((k % 16) <= 1 && k >= 16)) ? 2'b11 : 2'b00);
        chk("bst_errsym", err_sym_ct_o, stat(10));
        chk("bst_errbit", err_bit_ct_o, stat(20));

        // RANDOM rate 0: every symbol
        cfg(2'd2, 8'd0, 4'd0, 4'd1, 2'b10, 32'd0);
        reset_dut();
        for (int k = 0; k < 50; k++) send_chk("rnd0", 2'b01, 2'b10);
        chk("rnd0_errbit", err_bit_ct_o, stat(50));

        // RANDOM rate 4 against golden LFSR
        cfg(2'd2, 8'd0, 4'd4, 4'd1, 2'b01, 32'd0);
        reset_dut();
        l = 16'hACE1;
        cnt = 0;
        for (int k = 0; k < 4096; k++) begin
            e = (l[3:0] == 4'd0) ? 2'b01 : 2'b00;
            if (e != 2'b00) cnt++;
            send_chk("rnd4", 2'b00, e);
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
        chk("rnd4_symct", sym_ct_o, 32'd4096);
        chk("rnd4_errsym", err_sym_ct_o, stat(cnt));

        // Gapped valid
        cfg(2'd1, 8'd8, 4'd0, 4'd1, 2'b01, 32'd0);
        reset_dut();
        for (int k = 0; k < 64; k++) begin
            send_chk("gap", 2'b00, (k % 8 == 7) ? 2'b01 : 2'b00);
            send(1'b0, 2'b00);
            chk("gap_idle_v", 32'(valid_o), 32'd0);
            chk("gap_idle_err", 32'(err_o), 32'd0);
        end
        chk("gap_symct", sym_ct_o, 32'd64);
        chk("gap_errsym", err_sym_ct_o, stat(8));

        // Reset during the 2nd burst symbol
        cfg(2'd3, 8'd16, 4'd0, 4'd3, 2'b11, 32'd0);
        reset_dut();
        for (int k = 0; k < 16; k++) send_chk("mrb", 2'b00, (k == 15) ? 2'b11 : 2'b00);
        rst = 1'b1;
        send(1'b1, 2'b00);
        rst = 1'b0;
        chk("mrb_rst_v", 32'(valid_o), 32'd0);
        chk("mrb_rst_sym", 32'(sym_o), 32'd0);
        chk("mrb_rst_err", 32'(err_o), 32'd0);
        chk("mrb_rst_symct", sym_ct_o, 32'd0);
        chk("mrb_rst_errsym", err_sym_ct_o, 32'd0);
        for (int k = 0; k < 20; k++)
            send_chk("mrb_post", 2'b00, (k >= 15 && k <= 17) ? 2'b11 : 2'b00);
        chk("mrb_errbit", err_bit_ct_o, stat(6));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
